// File: rtl/pong_pkg.sv
// pong_pkg: shared encodings for the Pong match controller.
//   state_e      - match FSM states (also the game_state display encoding)
//   Player*      - server identity
//   Dir*         - ball_dir launch direction
//   Win*         - winner output encoding
//   SpeedW       - width of speed_level
package pong_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StServe    = 3'd1,
    StPlay     = 3'd2,
    StPoint    = 3'd3,
    StGameOver = 3'd4
  } state_e;

  localparam int unsigned ScoreW  = 4;
  localparam int unsigned SpeedW  = 2;
  localparam int unsigned WinnerW = 2;

  localparam logic PlayerP1 = 1'b0;
  localparam logic PlayerP2 = 1'b1;

  localparam logic DirToP2 = 1'b0;
  localparam logic DirToP1 = 1'b1;

  localparam logic [WinnerW-1:0] WinNone = 2'b00;
  localparam logic [WinnerW-1:0] WinP1   = 2'b01;
  localparam logic [WinnerW-1:0] WinP2   = 2'b10;

  localparam logic [SpeedW-1:0] SpeedMax = 2'd3;

  // The serving player launches the ball toward the opponent.
  function automatic logic serve_dir(input logic server);
    return (server == PlayerP1) ? DirToP2 : DirToP1;
  endfunction

endpackage

// File: rtl/delay_timer.sv
// delay_timer: loadable down-counter shared by the timed match states.
//   clk, reset - clock, synchronous active-high reset
//   load       - load strobe (has priority over counting)
//   load_val   - value to load; a state of N cycles loads N-1
//   en         - count enable; the counter holds at zero
//   done       - count is zero
//   count      - current count (lets the owner act one cycle before done)
module delay_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done  = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong match sequencer (idle, serve countdown, rally, point pause, game over).
// Keeps both scores and drives paddle re-centre, ball launch/direction and speed strobes.
//   clk, reset                  - clock, synchronous active-high reset
//   start_btn                   - debounced start level (rising edge starts a match)
//   miss_left, miss_right       - ball passed P1 / P2 paddle (1-cycle pulses)
//   paddle_hit                  - ball struck a paddle (1-cycle pulse)
//   reset_game, ball_launch     - 1-cycle strobes to paddle / ball blocks
//   ball_dir                    - launch direction, 0 toward P2, 1 toward P1
//   paddles_en                  - paddle motion allowed
//   score1, score2, winner      - match result
//   speed_level                 - ball speed step
//   game_state                  - current state encoding
// Optional feature: define RALLY_SPEEDUP_EN to raise speed_level every 4 paddle hits in a rally.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_DELAY = 25_000_000,
  parameter int unsigned POINT_DELAY = 50_000_000,
  parameter int unsigned WIN_SCORE   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       paddle_hit,
  output logic       reset_game,
  output logic       ball_launch,
  output logic       ball_dir,
  output logic       paddles_en,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [1:0] speed_level,
  output logic [2:0] game_state
);

  localparam int unsigned TimerMax = (SERVE_DELAY > POINT_DELAY) ? SERVE_DELAY : POINT_DELAY;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam logic [TimerW-1:0] ServeLoad = TimerW'(SERVE_DELAY - 1);
  localparam logic [TimerW-1:0] PointLoad = TimerW'(POINT_DELAY - 1);
  localparam logic [ScoreW-1:0] WinScore  = ScoreW'(WIN_SCORE);

  state_e state_q;
  logic   start_prev_q;
  logic   server_q;

  logic              start_edge;
  logic              go_serve;
  logic              go_point;
  logic              go_over;
  logic [ScoreW-1:0] score1_inc;
  logic [ScoreW-1:0] score2_inc;
  logic              timer_load;
  logic [TimerW-1:0] timer_load_val;
  logic              timer_en;
  logic              timer_done;
  logic [TimerW-1:0] timer_count;

  always_comb begin
    start_edge = start_btn & ~start_prev_q;
    score1_inc = score1 + ScoreW'(1);
    score2_inc = score2 + ScoreW'(1);
    go_serve   = (((state_q == StIdle) || (state_q == StGameOver)) && start_edge) ||
                 ((state_q == StPoint) && timer_done);
    // Simultaneous misses score nothing, so only a lone miss can end the match.
    go_over    = (state_q == StPlay) && (miss_left ^ miss_right) &&
                 (miss_left ? (score2_inc == WinScore) : (score1_inc == WinScore));
    go_point   = (state_q == StPlay) && (miss_left | miss_right) && !go_over;
    timer_load     = go_serve | go_point;
    timer_load_val = go_serve ? ServeLoad : PointLoad;
    timer_en       = (state_q == StServe) || (state_q == StPoint);
  end

  delay_timer #(
    .WIDTH (TimerW)
  ) u_delay_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .en       (timer_en),
    .done     (timer_done),
    .count    (timer_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b0;
      server_q     <= PlayerP1;
      reset_game   <= 1'b0;
      ball_launch  <= 1'b0;
      ball_dir     <= 1'b0;
      paddles_en   <= 1'b0;
      score1       <= '0;
      score2       <= '0;
      winner       <= WinNone;
    end else begin
      start_prev_q <= start_btn;
      reset_game   <= 1'b0;
      ball_launch  <= 1'b0;
      unique case (state_q)
        StIdle, StGameOver: begin
          if (start_edge) begin
            state_q    <= StServe;
            score1     <= '0;
            score2     <= '0;
            winner     <= WinNone;
            server_q   <= PlayerP1;
            reset_game <= 1'b1;
            paddles_en <= 1'b1;
            // A one-cycle serve launches in its only (first) cycle.
            if (SERVE_DELAY == 1) begin
              ball_launch <= 1'b1;
              ball_dir    <= serve_dir(PlayerP1);
            end
          end
        end
        StServe: begin
          if (timer_done) begin
            state_q <= StPlay;
          end else if (timer_count == TimerW'(1)) begin
            // Next cycle is the last serve cycle.
            ball_launch <= 1'b1;
            ball_dir    <= serve_dir(server_q);
          end
        end
        StPlay: begin
          if (miss_left && miss_right) begin
            state_q    <= StPoint;
            paddles_en <= 1'b0;
          end else if (miss_left) begin
            score2     <= score2_inc;
            paddles_en <= 1'b0;
            if (go_over) begin
              state_q <= StGameOver;
              winner  <= WinP2;
            end else begin
              state_q  <= StPoint;
              server_q <= PlayerP1;
            end
          end else if (miss_right) begin
            score1     <= score1_inc;
            paddles_en <= 1'b0;
            if (go_over) begin
              state_q <= StGameOver;
              winner  <= WinP1;
            end else begin
              state_q  <= StPoint;
              server_q <= PlayerP2;
            end
          end
        end
        StPoint: begin
          if (timer_done) begin
            state_q    <= StServe;
            reset_game <= 1'b1;
            paddles_en <= 1'b1;
            if (SERVE_DELAY == 1) begin
              ball_launch <= 1'b1;
              ball_dir    <= serve_dir(server_q);
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          paddles_en <= 1'b0;
        end
      endcase
    end
  end

  assign game_state = state_q;

`ifdef RALLY_SPEEDUP_EN
  logic [2:0]        hit_cnt_q;
  logic [SpeedW-1:0] speed_q;

  always_ff @(posedge clk) begin
    if (reset || go_serve || go_point || go_over) begin
      hit_cnt_q <= '0;
      speed_q   <= '0;
    end else if ((state_q == StPlay) && paddle_hit) begin
      hit_cnt_q <= hit_cnt_q + 3'd1;
      // Every 4th hit of the rally steps the speed.
      if ((hit_cnt_q[1:0] == 2'b11) && (speed_q != SpeedMax)) begin
        speed_q <= speed_q + SpeedW'(1);
      end
    end
  end

  assign speed_level = speed_q;
`else
  logic unused_paddle_hit;
  assign unused_paddle_hit = paddle_hit;
  assign speed_level       = '0;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: scoreboard bench for pong_game_ctrl (SERVE_DELAY=4, POINT_DELAY=3,
// WIN_SCORE=3). Each driven cycle pushes the outputs expected after the next clock edge;
// a negedge monitor pops and compares them.
module tb_pong_game_ctrl;

  localparam logic [2:0] SIdle  = 3'd0;
  localparam logic [2:0] SServe = 3'd1;
  localparam logic [2:0] SPlay  = 3'd2;
  localparam logic [2:0] SPoint = 3'd3;
  localparam logic [2:0] SOver  = 3'd4;

  bit clk;
  always #5 clk = ~clk;

  logic       reset, start_btn, miss_left, miss_right, paddle_hit;
  logic       reset_game, ball_launch, ball_dir, paddles_en;
  logic [3:0] score1, score2;
  logic [1:0] winner, speed_level;
  logic [2:0] game_state;

  pong_game_ctrl #(
    .SERVE_DELAY (4),
    .POINT_DELAY (3),
    .WIN_SCORE   (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_btn   (start_btn),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .paddle_hit  (paddle_hit),
    .reset_game  (reset_game),
    .ball_launch (ball_launch),
    .ball_dir    (ball_dir),
    .paddles_en  (paddles_en),
    .score1      (score1),
    .score2      (score2),
    .winner      (winner),
    .speed_level (speed_level),
    .game_state  (game_state)
  );

  typedef struct {
    logic [2:0] state;
    logic       rg, la, dir, pen;
    logic [3:0] s1, s2;
    logic [1:0] win, spd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  // Expected match status, updated by the stimulus as events happen.
  logic [3:0] sc1, sc2;
  logic [1:0] win, spd;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cyc++;
      check_eq("game_state", 8'(game_state), 8'(e.state));
      check_eq("reset_game", 8'(reset_game), 8'(e.rg));
      check_eq("ball_launch", 8'(ball_launch), 8'(e.la));
      check_eq("paddles_en", 8'(paddles_en), 8'(e.pen));
      check_eq("score1", 8'(score1), 8'(e.s1));
      check_eq("score2", 8'(score2), 8'(e.s2));
      check_eq("winner", 8'(winner), 8'(e.win));
      check_eq("speed_level", 8'(speed_level), 8'(e.spd));
      if (e.la) check_eq("ball_dir", 8'(ball_dir), 8'(e.dir));
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic tick(input logic st, input logic rs, input logic ml, input logic mr,
                      input logic hit, input logic [2:0] stt, input logic rg, input logic la,
                      input logic dir, input logic pen);
    exp_t e;
    start_btn  = st;
    reset      = rs;
    miss_left  = ml;
    miss_right = mr;
    paddle_hit = hit;
    e.state = stt;
    e.rg    = rg;
    e.la    = la;
    e.dir   = dir;
    e.pen   = pen;
    e.s1    = sc1;
    e.s2    = sc2;
    e.win   = win;
    e.spd   = spd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Remaining three serve cycles (launch on the 4th) followed by the first PLAY cycle.
  task automatic serve_tail(input logic dir);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, SServe, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SServe, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SServe, 1'b0, 1'b1, dir, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SPlay, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Remaining two POINT cycles (stray pulses ignored) followed by the first SERVE cycle.
  task automatic point_tail();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, SPoint, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, SPoint, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SServe, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    sc1 = '0;
    sc2 = '0;
    win = 2'b00;
    spd = 2'd0;

    // Reset and idle.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SIdle, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SIdle, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, SIdle, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start edge: serve by P1 toward P2. start_btn then stays high.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SServe, 1'b1, 1'b0, 1'b0, 1'b1);
    serve_tail(1'b0);

    // Rally with 16 paddle hits.
    for (int i = 1; i <= 16; i++) begin
`ifdef RALLY_SPEEDUP_EN
      spd = (i / 4 > 3) ? 2'd3 : 2'(i / 4);
`endif
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, SPlay, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SPlay, 1'b0, 1'b0, 1'b0, 1'b1);

    // miss_right: P1 scores, P2 serves toward P1.
    sc1 = 4'd1;
    spd = 2'd0;
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, SPoint, 1'b0, 1'b0, 1'b0, 1'b0);
    point_tail();
    serve_tail(1'b1);

    // Both misses together: no score, server unchanged.
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, SPoint, 1'b0, 1'b0, 1'b0, 1'b0);
    point_tail();
    serve_tail(1'b1);

    // Three miss_left rallies: P2 reaches WIN_SCORE.
    for (int r = 1; r <= 3; r++) begin
      sc2 = 4'(r);
      if (r == 3) begin
        win = 2'b10;
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, SOver, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, SPoint, 1'b0, 1'b0, 1'b0, 1'b0);
        point_tail();
        serve_tail(1'b0);
      end
    end

    // Game over is sticky: misses, hits and a held start change nothing.
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, SOver, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, SOver, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, SOver, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SOver, 1'b0, 1'b0, 1'b0, 1'b0);

    // New start edge clears the match.
    sc1 = '0;
    sc2 = '0;
    win = 2'b00;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SServe, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SServe, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset two cycles into SERVE: back to idle, launch never appears.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SIdle, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SIdle, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Top-level match sequencer for the Pong design. Owns the game state machine (idle, serve countdown, rally, point pause, game over), keeps both scores, and drives the control strobes consumed by the paddle_movement block (paddle re-centre) and the ball block (launch, direction, speed). Sits between the debounced start button and the ball/paddle datapath; it does not touch pixel or encoder logic.

## Interface
- SERVE_DELAY, 25_000_000: cycles spent in SERVE before launch (≥1)
- POINT_DELAY, 50_000_000: cycles spent in POINT pause (≥1)
- WIN_SCORE, 7: score that ends the match (1..15)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock domain only
- start_btn  in  1  debounced, already synchronous start level
- miss_left  in  1  1-cycle pulse: ball passed P1 (left) paddle
- miss_right  in  1  1-cycle pulse: ball passed P2 (right) paddle
- paddle_hit  in  1  1-cycle pulse: ball struck either paddle
- reset_game  out  1  1-cycle paddle re-centre strobe
- ball_launch  out  1  1-cycle launch strobe
- ball_dir  out  1  launch direction: 0 = toward P2, 1 = toward P1
- paddles_en  out  1  paddle motion allowed
- score1, score2  out  4  player scores
- winner  out  2  00 none, 01 P1, 10 P2
- speed_level  out  2  ball speed step (see Configuration)
- game_state  out  3  current state encoding, for display/debug

## Operation
- States: IDLE, SERVE, PLAY, POINT, GAME_OVER.
- start edge = start_btn high and registered previous value low; edges outside IDLE/GAME_OVER ignored.
- IDLE/GAME_OVER + start edge → SERVE; scores, winner, server cleared (server = P1).
- SERVE: lasts exactly SERVE_DELAY cycles; ball_launch high in last SERVE cycle, ball_dir = server (P1 serves toward P2: dir 0); → PLAY.
- PLAY: miss_left alone → score2+1, server = P1; miss_right alone → score1+1, server = P2; → POINT. Both in same cycle → no score change, server unchanged, → POINT.
- If incremented score equals WIN_SCORE → GAME_OVER instead of POINT; winner set same cycle; scores frozen.
- POINT: lasts exactly POINT_DELAY cycles; → SERVE.
- reset_game high exactly in the first cycle of every SERVE visit.
- paddles_en = 1 in SERVE and PLAY only.
- miss/hit pulses outside PLAY ignored. Scores never exceed WIN_SCORE; no wrap.

## Timing
- All outputs registered. Reset values: state IDLE, all outputs 0.
- Start edge sampled at edge n → SERVE, reset_game=1 at n+1.
- Miss sampled at edge n → new score, state POINT/GAME_OVER visible at n+1.
- Timer: one shared down-counter, loaded on state entry; state exits on the cycle after count reaches 0.
- reset asserted mid-state (including mid-countdown) → IDLE next edge, scores 0, pending strobes dropped.

## Configuration
- RALLY_SPEEDUP_EN defined: 3-bit hit counter increments on paddle_hit in PLAY; speed_level increments every 4 hits, saturates at 3; counter and speed_level cleared on entry to POINT, GAME_OVER, SERVE.
- Undefined: no hit counter; speed_level tied 0; paddle_hit unused.

## Structure
- pong_pkg: state localparams, player/winner encodings, ball_dir encoding, speed_level width.
- One sub-module: delay_timer (load value, load strobe, count enable, done flag), instantiated once, sized to max(SERVE_DELAY, POINT_DELAY).
- FSM, score registers, edge detect and optional speed logic stay in pong_game_ctrl.

## Test plan
Bench params: SERVE_DELAY=4, POINT_DELAY=3, WIN_SCORE=3.
- Reset, then start_btn 0→1 → reset_game=1 for 1 cycle, paddles_en=1, ball_launch on 4th SERVE cycle with ball_dir=0, then game_state=PLAY.
- In PLAY pulse miss_right → score1=1 next cycle, paddles_en=0 for 3 cycles, then SERVE with reset_game=1, launch with ball_dir=1.
- miss_left and miss_right same cycle → scores unchanged, POINT, next launch ball_dir unchanged.
- Three miss_left rallies → score2=3, winner=10, GAME_OVER; further misses/start-held-high no change; new start edge → scores 0, winner 00.
- reset asserted 2 cycles into SERVE → next cycle IDLE, all outputs 0, no ball_launch.
- RALLY_SPEEDUP_EN: 9 paddle_hit pulses in PLAY → speed_level=2; 16 → 3 (saturate); miss → 0. Without macro → speed_level stays 0.
